vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Raster timing generator for 640x480@60 VGA.
- Produces pixel coordinates, sync pulses, a visible flag and line/frame strobes, all aligned to the same pixel.
- Sits directly upstream of the pattern generators: column_o/row_o feed their column_i/row_i, and hsync_o/vsync_o go to the connector.
- Advances one pixel per clock on which pix_en_i is high, so it runs from a 25 MHz clock (pix_en_i tied high) or a faster clock with an enable.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, level of hsync_o/vsync_o during the pulse (0 = negative sync)

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
pix_en_i  input  1  pixel tick; counters advance on clk_i edges where high
column_o  output  10  horizontal position, 0..H_TOTAL-1
row_o  output  10  vertical position, 0..V_TOTAL-1
visible_o  output  1  high when column_o<H_VISIBLE and row_o<V_VISIBLE
hsync_o  output  1  horizontal sync
vsync_o  output  1  vertical sync
line_start_o  output  1  one-clk pulse when column_o becomes 0
frame_start_o  output  1  one-clk pulse when column_o and row_o both become 0

Behaviour:
- Derived totals:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK = 800.
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK = 525.
  - Both must be <= 1024; elaboration error otherwise.
- All outputs are registered; there is no combinational path from pix_en_i to any output.
- Reset (rst_n_i low, asynchronous assert, synchronous-release use):
  - column_o = H_TOTAL-1 (799), row_o = V_TOTAL-1 (524).
  - visible_o = 0; hsync_o = vsync_o = !SYNC_ACTIVE.
  - line_start_o = frame_start_o = 0.
- First enabled tick after reset moves to (0,0) with visible_o=1 and line_start_o=frame_start_o=1.
- Horizontal counter, on each edge with pix_en_i=1:
  - column_o increments.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Advances only on a tick where column_o wraps.
  - At V_TOTAL-1 it wraps to 0 on that same tick.
- hsync_o = SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= column_o < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise !SYNC_ACTIVE.
- vsync_o = SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= row_o < V_VISIBLE+V_FRONT+V_SYNC (490..491), across whole lines.
- Alignment: hsync_o, vsync_o and visible_o always correspond to the column_o/row_o presented in the same cycle, with zero skew. Compute them from the next counter values.
- Strobes:
  - line_start_o = 1 for exactly one clk, the cycle after an enabled tick that wrapped the column; 0 otherwise.
  - frame_start_o is the same, but only when row_o also wrapped.
  - Both are 0 on every clk where pix_en_i was 0 on the preceding edge.
- pix_en_i low: all position and sync outputs hold their values indefinitely.
- Reset mid-frame returns immediately (asynchronously) to the reset values. No partial pulse survives.

Decomposition:
- Shared include vga_640x480.vh holds localparams for the default H_/V_ timings and SYNC_ACTIVE. The pattern generators use the same H_VISIBLE/V_VISIBLE constants in place of literals.
- One natural sub-module: vga_axis_counter.
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Inputs: clk_i, rst_n_i, inc_i.
  - Outputs: count_o, wrap_o (combinational, = inc_i at terminal count), sync_active_o, visible_o.
  - Instantiated twice: horizontal with inc_i=pix_en_i; vertical with inc_i=horizontal wrap_o.

Test Plan:
- Hold rst_n_i low, pix_en_i=1 -> column_o=799, row_o=524, visible_o=0, hsync_o=vsync_o=1, strobes 0. Release, one clk -> column_o=0, row_o=0, visible_o=1, line_start_o=frame_start_o=1. Next clk -> both strobes 0.
- Run one line -> hsync_o=0 for exactly 96 ticks, columns 656..751. visible_o falls at column_o=640. At 799->0, row_o increments and line_start_o pulses once.
- Run a full frame -> vsync_o=0 exactly on rows 490..491 (1600 ticks). frame_start_o pulses once per 420000 ticks, at (0,0).
- pix_en_i high every 4th clk -> outputs change only after enabled edges, and each strobe lasts exactly 1 clk. Same frame length as above measured in ticks.
- Assert rst_n_i at column 300 / row 200 -> outputs go to reset values without waiting for a clk edge. After release, the frame restarts at (0,0).
- Instantiate with SYNC_ACTIVE=1 -> hsync_o/vsync_o polarity inverted, timings identical.

Source files
------------

// File: rtl/vga_sync_pkg.sv
// Shared constants for the 640x480@60 raster timing generator and its pattern consumers.
package vga_sync_pkg;

   localparam int unsigned CNT_W     = 10;
   localparam int unsigned MAX_TOTAL = 1 << CNT_W;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;
   localparam bit          DEF_SYNC_ACTIVE = 1'b0;

   function automatic int unsigned axis_total(input int unsigned visible,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus decodes of its *next* value,
// so the parent can register sync/visible in step with the count.
module vga_axis_counter
   import vga_sync_pkg::*;
#(
   parameter int unsigned VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned FRONT   = DEF_H_FRONT,
   parameter int unsigned SYNC    = DEF_H_SYNC,
   parameter int unsigned BACK    = DEF_H_BACK
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o,
   output logic             wrap_o,
   output logic             sync_active_o,
   output logic             visible_o
);

   localparam int unsigned TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam int unsigned SYNC_START = VISIBLE + FRONT;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      wrap_o  = inc_i && (count_q == CNT_W'(TOTAL - 1));
      if (inc_i) begin
         count_d = wrap_o ? '0 : count_q + CNT_W'(1);
      end
      // 32-bit compares so a range ending exactly at MAX_TOTAL cannot alias to 0
      sync_active_o = (32'(count_d) >= SYNC_START) && (32'(count_d) < SYNC_END);
      visible_o     = 32'(count_d) < VISIBLE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= CNT_W'(TOTAL - 1);
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel coordinates, sync pulses, visible flag and
// line/frame strobes, all registered and aligned to the same pixel.
module vga_sync
   import vga_sync_pkg::*;
#(
   parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT     = DEF_H_FRONT,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BACK      = DEF_H_BACK,
   parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT     = DEF_V_FRONT,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BACK      = DEF_V_BACK,
   parameter bit          SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             pix_en_i,
   output logic [CNT_W-1:0] column_o,
   output logic [CNT_W-1:0] row_o,
   output logic             visible_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             line_start_o,
   output logic             frame_start_o
);

   localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   generate
      if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
         $error("vga_sync: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
      end
   endgenerate

   logic h_wrap, h_sync_nxt, h_vis_nxt;
   logic v_wrap, v_sync_nxt, v_vis_nxt;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_axis (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .inc_i         (pix_en_i),
      .count_o       (column_o),
      .wrap_o        (h_wrap),
      .sync_active_o (h_sync_nxt),
      .visible_o     (h_vis_nxt)
   );

   // Rows advance only on the tick that wraps the column
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_axis (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .inc_i         (h_wrap),
      .count_o       (row_o),
      .wrap_o        (v_wrap),
      .sync_active_o (v_sync_nxt),
      .visible_o     (v_vis_nxt)
   );

   logic visible_q, visible_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;

   always_comb begin
      visible_d     = h_vis_nxt && v_vis_nxt;
      hsync_d       = h_sync_nxt ? SYNC_ACTIVE : !SYNC_ACTIVE;
      vsync_d       = v_sync_nxt ? SYNC_ACTIVE : !SYNC_ACTIVE;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         visible_q     <= 1'b0;
         hsync_q       <= !SYNC_ACTIVE;
         vsync_q       <= !SYNC_ACTIVE;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         visible_q     <= visible_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign visible_o     = visible_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default 640x480 instance plus a tiny positive-sync raster
// (15x8) so whole frames fit in a short run.
module tb_vga_sync;

   logic       clk;
   logic       rst_n;
   logic       pix_en;

   logic [9:0] m_col, m_row;
   logic       m_vis, m_hs, m_vs, m_ls, m_fs;
   logic [9:0] s_col, s_row;
   logic       s_vis, s_hs, s_vs, s_ls, s_fs;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   vga_sync u_main (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .pix_en_i      (pix_en),
      .column_o      (m_col),
      .row_o         (m_row),
      .visible_o     (m_vis),
      .hsync_o       (m_hs),
      .vsync_o       (m_vs),
      .line_start_o  (m_ls),
      .frame_start_o (m_fs)
   );

   vga_sync #(
      .H_VISIBLE   (8),
      .H_FRONT     (2),
      .H_SYNC      (3),
      .H_BACK      (2),
      .V_VISIBLE   (4),
      .V_FRONT     (1),
      .V_SYNC      (2),
      .V_BACK      (1),
      .SYNC_ACTIVE (1'b1)
   ) u_small (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .pix_en_i      (pix_en),
      .column_o      (s_col),
      .row_o         (s_row),
      .visible_o     (s_vis),
      .hsync_o       (s_hs),
      .vsync_o       (s_vs),
      .line_start_o  (s_ls),
      .frame_start_o (s_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference raster model, index 0 = main, 1 = small
   int unsigned mdl_col[2];
   int unsigned mdl_row[2];
   bit          mdl_ls[2];
   bit          mdl_fs[2];

   function automatic int unsigned htot(input int d);  return d == 0 ? 800 : 15; endfunction
   function automatic int unsigned vtot(input int d);  return d == 0 ? 525 : 8;  endfunction
   function automatic int unsigned hvis(input int d);  return d == 0 ? 640 : 8;  endfunction
   function automatic int unsigned vvis(input int d);  return d == 0 ? 480 : 4;  endfunction
   function automatic int unsigned hs_lo(input int d); return d == 0 ? 656 : 10; endfunction
   function automatic int unsigned hs_hi(input int d); return d == 0 ? 752 : 13; endfunction
   function automatic int unsigned vs_lo(input int d); return d == 0 ? 490 : 5;  endfunction
   function automatic int unsigned vs_hi(input int d); return d == 0 ? 492 : 7;  endfunction
   function automatic bit          sact(input int d);  return d == 0 ? 1'b0 : 1'b1; endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mdl_col[d] = htot(d) - 1;
         mdl_row[d] = vtot(d) - 1;
         mdl_ls[d]  = 1'b0;
         mdl_fs[d]  = 1'b0;
      end
   endtask

   task automatic model_tick(input bit en);
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            mdl_col[d] = htot(d) - 1;
            mdl_row[d] = vtot(d) - 1;
            mdl_ls[d]  = 1'b0;
            mdl_fs[d]  = 1'b0;
         end else if (en) begin
            mdl_ls[d] = (mdl_col[d] == htot(d) - 1);
            mdl_fs[d] = mdl_ls[d] && (mdl_row[d] == vtot(d) - 1);
            if (mdl_ls[d]) begin
               mdl_col[d] = 0;
               mdl_row[d] = (mdl_row[d] == vtot(d) - 1) ? 0 : mdl_row[d] + 1;
            end else begin
               mdl_col[d] = mdl_col[d] + 1;
            end
         end else begin
            mdl_ls[d] = 1'b0;
            mdl_fs[d] = 1'b0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input int d);
      logic [9:0] c, r;
      logic       v, h, vs, l, f;
      string      p;
      bit         exp_hs, exp_vs;
      if (d == 0) begin
         c = m_col; r = m_row; v = m_vis; h = m_hs; vs = m_vs; l = m_ls; f = m_fs; p = "main";
      end else begin
         c = s_col; r = s_row; v = s_vis; h = s_hs; vs = s_vs; l = s_ls; f = s_fs; p = "small";
      end
      exp_hs = (mdl_col[d] >= hs_lo(d) && mdl_col[d] < hs_hi(d)) ? sact(d) : !sact(d);
      exp_vs = (mdl_row[d] >= vs_lo(d) && mdl_row[d] < vs_hi(d)) ? sact(d) : !sact(d);
      chk({p, " column"},  32'(c),  mdl_col[d]);
      chk({p, " row"},     32'(r),  mdl_row[d]);
      chk({p, " visible"}, 32'(v),  32'(mdl_col[d] < hvis(d) && mdl_row[d] < vvis(d)));
      chk({p, " hsync"},   32'(h),  32'(exp_hs));
      chk({p, " vsync"},   32'(vs), 32'(exp_vs));
      chk({p, " line_start"},  32'(l), 32'(mdl_ls[d]));
      chk({p, " frame_start"}, 32'(f), 32'(mdl_fs[d]));
   endtask

   // One clock edge with the given enable; leaves time at posedge+1
   task automatic step(input bit en);
      pix_en = en;
      @(posedge clk);
      model_tick(en);
      #1;
   endtask

   task automatic check_main_hand(input string name, input int unsigned col, input int unsigned row,
                                  input bit vis, input bit hs, input bit vs, input bit ls, input bit fs);
      chk({name, " column"},      32'(m_col), col);
      chk({name, " row"},         32'(m_row), row);
      chk({name, " visible"},     32'(m_vis), 32'(vis));
      chk({name, " hsync"},       32'(m_hs),  32'(hs));
      chk({name, " vsync"},       32'(m_vs),  32'(vs));
      chk({name, " line_start"},  32'(m_ls),  32'(ls));
      chk({name, " frame_start"}, 32'(m_fs),  32'(fs));
   endtask

   typedef struct {
      string       name;
      bit          en;
      int unsigned n;
      int unsigned col;
      int unsigned row;
      bit          vis;
      bit          hs;
      bit          vs;
      bit          ls;
      bit          fs;
   } vec_t;

   vec_t vecs[11];

   initial begin
      bit          ok;
      int unsigned hs_low, hs_first, hs_last, ls_cnt, vis_fall, row_before;
      int unsigned ticks, fs_cnt, ls_clk_cnt, vs_ticks, last_fs_tick;
      bit          prev_vis, seen_fs;

      vecs[0]  = '{"first_tick",  1'b1, 1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{"second_tick", 1'b1, 1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"last_vis",    1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{"first_blank", 1'b1, 1,   640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{"hs_start",    1'b1, 16,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{"hs_last",     1'b1, 95,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{"hs_end",      1'b1, 1,   752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{"line_end",    1'b1, 47,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{"line_wrap",   1'b1, 1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{"hold",        1'b0, 5,   0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{"resume",      1'b1, 1,   1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset with the enable already high
      rst_n  = 1'b0;
      pix_en = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_main_hand("reset", 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_model(1);
      rst_n = 1'b1;

      // Directed vectors from the release point
      for (int i = 0; i < 11; i++) begin
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            step(vecs[i].en);
            check_model(1);
         end
         check_main_hand(vecs[i].name, vecs[i].col, vecs[i].row, vecs[i].vis,
                         vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs);
      end

      // One full line on the main raster from column 0
      ok = 1'b0;
      for (int i = 0; i < 1700; i++) begin
         if (m_col == 10'd0) begin
            ok = 1'b1;
            break;
         end
         step(1'b1);
      end
      chk("reach line start", 32'(ok), 1);
      hs_low = 0; hs_first = 0; hs_last = 0; ls_cnt = 0; vis_fall = 0;
      prev_vis = m_vis;
      row_before = mdl_row[0];
      for (int i = 0; i < 800; i++) begin
         step(1'b1);
         check_model(0);
         if (m_hs == 1'b0) begin
            if (hs_low == 0) hs_first = 32'(m_col);
            hs_last = 32'(m_col);
            hs_low++;
         end
         if (prev_vis && !m_vis) vis_fall = 32'(m_col);
         prev_vis = m_vis;
         if (m_ls) ls_cnt++;
      end
      chk("line hsync width",  hs_low,   96);
      chk("line hsync first",  hs_first, 656);
      chk("line hsync last",   hs_last,  751);
      chk("line visible fall", vis_fall, 640);
      chk("line strobes",      ls_cnt,   1);
      chk("line row advance",  32'(m_row), row_before + 1);

      // Enable every 4th clock: small raster runs exactly two frames (240 ticks)
      ticks = 0; fs_cnt = 0; ls_clk_cnt = 0; vs_ticks = 0; last_fs_tick = 0; seen_fs = 1'b0;
      for (int i = 0; i < 960; i++) begin
         step((i % 4) == 3);
         check_model(0);
         check_model(1);
         if ((i % 4) == 3) begin
            ticks++;
            if (s_vs) vs_ticks++;
         end
         if (s_ls) ls_clk_cnt++;
         if (s_fs) begin
            fs_cnt++;
            if (seen_fs) chk("frame period ticks", ticks - last_fs_tick, 120);
            last_fs_tick = ticks;
            seen_fs = 1'b1;
         end
      end
      chk("small frame strobes", fs_cnt,     2);
      chk("small line strobes",  ls_clk_cnt, 16);
      chk("small vsync ticks",   vs_ticks,   60);

      // Asynchronous reset right after a line strobe, checked before the next edge
      ok = 1'b0;
      for (int i = 0; i < 1700; i++) begin
         step(1'b1);
         if (m_col == 10'd0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach line wrap", 32'(ok), 1);
      chk("strobe before reset", 32'(m_ls), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_main_hand("async_reset", 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      model_reset();
      check_model(1);
      step(1'b1);
      check_main_hand("held_reset", 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1);
      check_main_hand("restart", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check_model(1);
      step(1'b1);
      check_main_hand("restart_next", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_model(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
